// File: rtl/axi_mcast_b_merger.sv
// axi_mcast_b_merger: merges per-port B beats of a multicast write into one slave B beat; AXI_MCAST_B_MERGER_TIMEOUT_EN adds forced completion.
module axi_mcast_b_merger #(
  parameter int NumMstPorts = 4,
  parameter int IdWidth = 4,
  parameter int FifoDepth = 4
`ifdef AXI_MCAST_B_MERGER_TIMEOUT_EN
  , parameter int TimeoutCycles = 1024
`endif
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [IdWidth-1:0]             cmd_id_i,
  input  logic [NumMstPorts-1:0]         cmd_mask_i,
  input  logic [NumMstPorts-1:0]         mst_b_valid_i,
  output logic [NumMstPorts-1:0]         mst_b_ready_o,
  input  logic [NumMstPorts*IdWidth-1:0] mst_b_id_i,
  input  logic [NumMstPorts*2-1:0]       mst_b_resp_i,
  output logic                           slv_b_valid_o,
  input  logic                           slv_b_ready_i,
  output logic [IdWidth-1:0]             slv_b_id_o,
  output logic [1:0]                     slv_b_resp_o,
  output logic                           busy_o,
  output logic                           timeout_o
);
  localparam int AW = $clog2(FifoDepth);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, RESP = 2'd2;
  logic [IdWidth-1:0] id_mem_q [FifoDepth];
  logic [NumMstPorts-1:0] mask_mem_q [FifoDepth];
  logic [AW:0] wptr_q, rptr_q;
  logic [1:0] state_q, state_d, acc_q, acc_d, merged, r;
  logic [NumMstPorts-1:0] rcvd_q, rcvd_d, hs, head_mask;
  logic [IdWidth-1:0] head_id;
  logic empty, full, push, pop, multi, done, last;
  assign empty = wptr_q == rptr_q;
  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_id = id_mem_q[rptr_q[AW-1:0]];
  assign head_mask = mask_mem_q[rptr_q[AW-1:0]];
  assign multi = (head_mask & (head_mask - 1'b1)) != '0;
  assign cmd_ready_o = !full;
  assign push = cmd_valid_i && !full && (cmd_mask_i != '0);
  assign pop = (state_q == RESP) && slv_b_ready_i;
  assign last = ((wptr_q - rptr_q) == (AW+1)'(1)) && !push;
  assign done = (rcvd_q | hs) == head_mask;
  assign slv_b_valid_o = state_q == RESP;
  assign slv_b_id_o = slv_b_valid_o ? head_id : '0;
  assign slv_b_resp_o = slv_b_valid_o ? acc_q : 2'b00;
  assign busy_o = !empty || (state_q != IDLE);
  // EXOKAY only survives a unicast; otherwise the worst of DECERR > SLVERR > OKAY wins
  always_comb begin
    mst_b_ready_o = '0;
    merged = acc_q;
    r = 2'b00;
    for (int j = 0; j < NumMstPorts; j++)
      mst_b_ready_o[j] = (state_q == COLLECT) && head_mask[j] && !rcvd_q[j] &&
                         (mst_b_id_i[j*IdWidth +: IdWidth] == head_id);
    hs = mst_b_ready_o & mst_b_valid_i;
    for (int j = 0; j < NumMstPorts; j++)
      if (hs[j]) begin
        r = (multi && mst_b_resp_i[j*2 +: 2] == 2'b01) ? 2'b00 : mst_b_resp_i[j*2 +: 2];
        merged = !multi ? r : (r > merged ? r : merged);
      end
  end
`ifdef AXI_MCAST_B_MERGER_TIMEOUT_EN
  localparam int CW = $clog2(TimeoutCycles) + 1;
  logic [CW-1:0] cnt_q;
  logic to_q, expired;
  assign expired = cnt_q == CW'(TimeoutCycles - 1);
  assign timeout_o = to_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == COLLECT) ? cnt_q + 1'b1 : '0;
      to_q <= (state_q == COLLECT) && !done && expired;
    end
  end
`else
  logic expired;
  assign expired = 1'b0;
  assign timeout_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rcvd_d = rcvd_q;
    acc_d = acc_q;
    if (state_q == IDLE) state_d = empty ? IDLE : COLLECT;
    else if (state_q == COLLECT) begin
      rcvd_d = rcvd_q | hs;
      acc_d = done ? merged : (expired ? 2'b11 : merged);
      state_d = (done || expired) ? RESP : COLLECT;
    end else if (pop) begin
      rcvd_d = '0;
      acc_d = 2'b00;
      state_d = last ? IDLE : COLLECT;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      state_q <= IDLE;
      rcvd_q <= '0;
      acc_q <= 2'b00;
    end else begin
      wptr_q <= wptr_q + (AW+1)'(push);
      rptr_q <= rptr_q + (AW+1)'(pop);
      state_q <= state_d;
      rcvd_q <= rcvd_d;
      acc_q <= acc_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem_q[wptr_q[AW-1:0]] <= cmd_id_i;
      mask_mem_q[wptr_q[AW-1:0]] <= cmd_mask_i;
    end
  end
endmodule

// File: tb/tb_axi_mcast_b_merger.sv
// tb_axi_mcast_b_merger: random scoreboard bench; per-port beat queues feed the DUT, a monitor checks merged B beats.
module tb_axi_mcast_b_merger;
  localparam int N = 4, IW = 4, D = 4;
  logic clk = 1'b0, rst;
  logic cmd_valid, cmd_ready, s_valid, s_ready, busy, tmo;
  logic [IW-1:0] cmd_id, s_id;
  logic [N-1:0] cmd_mask, b_valid, b_ready, hs_seen;
  logic [N*IW-1:0] b_id;
  logic [N*2-1:0] b_resp;
  logic [1:0] s_resp;
  int checks = 0, fails = 0;
  typedef struct { logic [IW-1:0] id; logic [1:0] resp; int seq; } beat_t;
  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } exp_t;
  beat_t port_q[N][$];
  exp_t exp_q[$];
  exp_t e;
  int seq_n = 0, done_n = 0, max_hs = 0;
  bit ports_en = 1, all_valid = 0, force_en = 0;
  logic [1:0] force_resp [N];
  logic pv = 1'b0;
  logic [IW-1:0] pid;
  logic [1:0] presp;

  always #5 clk = ~clk;

  axi_mcast_b_merger dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_id_i(cmd_id), .cmd_mask_i(cmd_mask),
    .mst_b_valid_i(b_valid), .mst_b_ready_o(b_ready), .mst_b_id_i(b_id), .mst_b_resp_i(b_resp),
    .slv_b_valid_o(s_valid), .slv_b_ready_i(s_ready), .slv_b_id_o(s_id), .slv_b_resp_o(s_resp),
    .busy_o(busy), .timeout_o(tmo)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // DECERR beats SLVERR beats OKAY; EXOKAY counts as OKAY unless only one port is targeted
  function automatic logic [1:0] merge_ref(logic [N-1:0] mask, logic [1:0] r [N]);
    logic [1:0] worst = 2'b00;
    for (int j = 0; j < N; j++)
      if (mask[j]) begin
        if ($countones(mask) == 1) return r[j];
        if (r[j] == 2'b11) worst = 2'b11;
        else if (r[j] == 2'b10 && worst != 2'b11) worst = 2'b10;
      end
    return worst;
  endfunction

  task automatic cycle(bit do_push, logic [IW-1:0] id, logic [N-1:0] mask);
    logic [1:0] r [N];
    @(negedge clk);
    for (int j = 0; j < N; j++)
      if (hs_seen[j]) begin
        void'(port_q[j].pop_front());
        b_valid[j] = 1'b0;
      end
    hs_seen = '0;
    cmd_valid = do_push;
    cmd_id = id;
    cmd_mask = mask;
    for (int j = 0; j < N; j++)
      if (!b_valid[j] && ports_en && port_q[j].size() > 0 && (all_valid || $urandom_range(0, 2) != 0)) begin
        b_valid[j] = 1'b1;
        b_id[j*IW +: IW] = port_q[j][0].id;
        b_resp[j*2 +: 2] = port_q[j][0].resp;
      end else if (!b_valid[j]) b_id[j*IW +: IW] = IW'($urandom_range(0, 3));
    s_ready = all_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
    #2;
    hs_seen = b_valid & b_ready;
    if ($countones(hs_seen) > max_hs) max_hs = $countones(hs_seen);
    for (int j = 0; j < N; j++)
      if (hs_seen[j]) check("beat_order", port_q[j][0].seq, done_n);
    if (cmd_valid && cmd_ready && cmd_mask != '0) begin
      for (int j = 0; j < N; j++) r[j] = force_en ? force_resp[j] : 2'($urandom_range(0, 3));
      for (int j = 0; j < N; j++)
        if (mask[j]) port_q[j].push_back('{id, r[j], seq_n});
      exp_q.push_back('{id, merge_ref(mask, r)});
      seq_n++;
    end
  endtask

  task automatic drain(string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 400) begin
      cycle(0, '0, '0);
      k++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    cycle(0, '0, '0);
    check({name, "_busy_idle"}, busy, 0);
  endtask

  always begin
    @(negedge clk);
    #2;
    if (rst) pv = 1'b0;
    else begin
      if (pv) begin
        check("valid_hold", s_valid, 1);
        check("id_hold", s_id, pid);
        check("resp_hold", s_resp, presp);
      end
      if (s_valid && s_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_b: got id %0h resp %0h, required no response", s_id, s_resp);
        end else begin
          e = exp_q.pop_front();
          check("b_id", s_id, e.id);
          check("b_resp", s_resp, e.resp);
        end
        done_n++;
      end
      pv = s_valid && !s_ready;
      pid = s_id;
      presp = s_resp;
    end
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_id = '0; cmd_mask = '0;
    b_valid = '0; b_id = '0; b_resp = '0; s_ready = 1'b0; hs_seen = '0;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("rst_slv_valid", s_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_mst_ready", b_ready, 0);
    check("rst_id_resp", {s_id, s_resp}, 0);
    check("rst_timeout", tmo, 0);
    rst = 1'b0;
    all_valid = 1; force_en = 1;
    force_resp[0] = 2'b00; force_resp[1] = 2'b11; force_resp[2] = 2'b10; force_resp[3] = 2'b01;
    cycle(1, 4'h7, 4'hF);
    drain("simul");
    check("simul_all_ready", max_hs, 4);
    all_valid = 0; force_en = 0;
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 2) == 0, IW'($urandom_range(0, 3)), N'($urandom_range(0, 15)));
    drain("random");
    ports_en = 0;
    for (int i = 0; i < 3; i++) cycle(1, IW'(i), 4'b0011);
    cycle(1, 4'h9, 4'b0000);
    cycle(0, '0, '0);
    check("zero_mask_ignored_ready", cmd_ready, 1);
    cycle(1, 4'h3, 4'b0101);
    cycle(0, '0, '0);
    check("full_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    cmd_valid = 1'b0;
    b_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int j = 0; j < N; j++) port_q[j].delete();
    hs_seen = '0; seq_n = 0; done_n = 0;
    #2;
    check("midrst_slv_valid", s_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    ports_en = 1;
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1) == 0, IW'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
    drain("post_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
